// File: rtl/branch_flush_controller.sv
`default_nettype none
// ============================================================================
// branch_flush_controller
//   Redirects the PC on taken EX-stage branches and flushes wrong-path stages.
//   Rev 1.0
// ============================================================================
module branch_flush_controller #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [1:0]        ex_branch_type,
  input  logic              alu_branch_flag,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              stall_in,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              busy,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [1:0] C_BR_NONE = 2'b00;
  localparam logic [1:0] C_BR_JAL  = 2'b01;
  localparam logic [1:0] C_BR_JALR = 2'b10;
  localparam logic [1:0] C_BR_COND = 2'b11;

  // Counter only needs to hold FLUSH_CYCLES-1; keep at least one bit.
  localparam int              FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e              state_q;
  logic [FC_W-1:0]     flush_cnt_q;
  logic                pc_load_q;
  logic                flush_if_id_q;
  logic                flush_id_ex_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   pc_target_q;
  logic [CNT_W-1:0]    branch_cnt_q;
  logic [CNT_W-1:0]    taken_cnt_q;

  logic                taken;
  logic                accept;
  logic [CNT_W-1:0]    branch_cnt_d;
  logic [CNT_W-1:0]    taken_cnt_d;
  logic [ADDR_W-1:0]   target_d;

  always_comb begin
    taken  = ex_valid & ((ex_branch_type == C_BR_JAL) |
                         (ex_branch_type == C_BR_JALR) |
                         ((ex_branch_type == C_BR_COND) & alu_branch_flag));
    accept = (state_q == IDLE) & ~stall_in & ex_valid & (ex_branch_type != C_BR_NONE);

    branch_cnt_d = (branch_cnt_q == '1) ? branch_cnt_q : branch_cnt_q + 1'b1;
    taken_cnt_d  = (taken_cnt_q  == '1) ? taken_cnt_q  : taken_cnt_q  + 1'b1;

    // JALR targets are architecturally halfword-aligned.
    target_d = (ex_branch_type == C_BR_JALR) ? {ex_target[ADDR_W-1:1], 1'b0} : ex_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      flush_cnt_q   <= '0;
      pc_load_q     <= 1'b0;
      flush_if_id_q <= 1'b0;
      flush_id_ex_q <= 1'b0;
      busy_q        <= 1'b0;
      pc_target_q   <= '0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            branch_cnt_q <= branch_cnt_d;
            if (taken) begin
              taken_cnt_q   <= taken_cnt_d;
              pc_target_q   <= target_d;
              pc_load_q     <= 1'b1;
              flush_if_id_q <= 1'b1;
              flush_id_ex_q <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= REDIRECT;
            end
          end
        end

        REDIRECT: begin
          if (!stall_in) begin
            pc_load_q     <= 1'b0;
            flush_id_ex_q <= 1'b0;
            if (FLUSH_CYCLES > 1) begin
              flush_cnt_q <= FLUSH_INIT;
              state_q     <= FLUSH;
            end else begin
              flush_if_id_q <= 1'b0;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end

        FLUSH: begin
          if (!stall_in) begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
            if (flush_cnt_q == FC_W'(1)) begin
              flush_if_id_q <= 1'b0;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end

        default: begin
          pc_load_q     <= 1'b0;
          flush_if_id_q <= 1'b0;
          flush_id_ex_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign pc_load      = pc_load_q;
  assign pc_target    = pc_target_q;
  assign flush_if_id  = flush_if_id_q;
  assign flush_id_ex  = flush_id_ex_q;
  assign busy         = busy_q;
  assign branch_count = branch_cnt_q;
  assign taken_count  = taken_cnt_q;

endmodule
`default_nettype wire

// File: doc/branch_flush_controller.md
# branch_flush_controller

Sequences control-flow redirection in the pipelined core. Once per cycle it evaluates the EX-stage branch type and the ALU branch flag, then decides whether the branch is taken. For a taken branch it issues a registered one-cycle PC load with the latched target and flushes wrong-path instructions for a fixed number of cycles. It honours pipeline stalls and keeps saturating branch/taken statistics counters. It sits between the EX stage and the PC/IF-ID/ID-EX pipeline registers.

## Interface
- ADDR_W, 32, PC/target width
- FLUSH_CYCLES, 2, total cycles flush_if_id stays asserted per redirect (≥1)
- CNT_W, 16, width of statistics counters

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- ex_valid  input  1  EX stage holds a valid instruction
- ex_branch_type  input  2  00 none, 01 JAL, 10 JALR, 11 conditional
- alu_branch_flag  input  1  ALU compare result (conditional branches only)
- ex_target  input  ADDR_W  computed branch target
- stall_in  input  1  pipeline frozen this cycle
- pc_load  output  1  load pc_target into PC
- pc_target  output  ADDR_W  redirect address
- flush_if_id  output  1  invalidate IF/ID register
- flush_id_ex  output  1  invalidate ID/EX register
- busy  output  1  state ≠ IDLE
- branch_count  output  CNT_W  accepted branch-type instructions
- taken_count  output  CNT_W  accepted taken branches

## Operation
- taken = ex_valid & (type==01 | type==10 | (type==11 & alu_branch_flag)). type 00 is never taken.
- An instruction is accepted when state==IDLE, stall_in==0, ex_valid==1 and type≠00.
- On acceptance, branch_count increments. If taken, taken_count also increments.
- Both counters saturate at 2^CNT_W−1; no wrap.
- States:
  - IDLE: all control outputs 0. On acceptance with taken: latch target and go to REDIRECT.
  - REDIRECT: pc_load=1, flush_if_id=1, flush_id_ex=1, pc_target=latched target.
    - If stall_in, stay in REDIRECT with outputs held.
    - Otherwise go to FLUSH if FLUSH_CYCLES>1, else IDLE.
  - FLUSH: flush_if_id=1 only. The down-counter starts at FLUSH_CYCLES−1 and decrements on each non-stalled cycle. It freezes while stall_in is high. Return to IDLE when it reaches 0.
- Target latch: for JALR (10), bit 0 of the latched target is forced to 0. Other types latch ex_target unchanged.
- EX inputs are ignored outside IDLE, since they belong to the wrong path. A taken branch arriving while busy is neither counted nor acted on.
- Not-taken conditional: counted, no redirect, state stays IDLE.
- Stall in IDLE: no acceptance, no counting. The decision occurs on the first non-stalled cycle with the instruction still present.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Timing
- Reset (rst_n low at a rising edge) forces on the next edge:
  - state IDLE, pc_load 0, flush_if_id 0, flush_id_ex 0, busy 0
  - pc_target 0, branch_count 0, taken_count 0, flush counter 0
- Reset has priority over every other event, including mid-REDIRECT or mid-FLUSH and a simultaneous acceptance.
- Acceptance sampled at edge N → pc_load/flush_id_ex high during cycle N+1 (one-cycle latency) for exactly one non-stalled cycle.
- flush_if_id is high for exactly FLUSH_CYCLES non-stalled cycles starting at N+1, plus any stalled cycles in between.
- busy is high from N+1 until flush completes. The next acceptance is possible at the first IDLE cycle.
- Counters update at the acceptance edge N and are visible in N+1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles during an active REDIRECT → all outputs and counters 0, busy 0 on the next cycle.
- JAL, ex_target=0x0000_0100, FLUSH_CYCLES=2, no stall:
  - N+1: pc_load=1, pc_target=0x100, both flushes 1.
  - N+2: flush_if_id only.
  - N+3: idle.
  - branch_count=1, taken_count=1.
- JALR, ex_target=0x0000_0203 → pc_target=0x0000_0202.
- Conditional, alu_branch_flag=0 → no pc_load, branch_count +1, taken_count unchanged. Same with flag=1 → redirect as in the JAL case.
- stall_in high for 3 cycles in REDIRECT → pc_load held 4 cycles total. Stall in FLUSH freezes the countdown. A taken branch presented while busy is ignored and not counted.
- Preload counters near saturation via 2^CNT_W accepted taken branches (CNT_W=4 build) → both counters stick at 15.
